// File: rtl/mem_write_monitor.sv
// mem_write_monitor
// Watches a CPU store stream and compares it, in order, against a small
// table of expected {address, data} writes. Stores that do not match the
// next expected entry are either tolerated (inside an inclusive ignore
// window) or end the check with a failure. An optional cycle limit ends a
// check that never completes. The verdict is held until the next Start.

module mem_write_monitor #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int TMO_W  = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  // CPU store port
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  // expected-write table load port
  input  logic              CfgWe,
  input  logic [IDX_W-1:0]  CfgIdx,
  input  logic [ADDR_W-1:0] CfgAdr,
  input  logic [DATA_W-1:0] CfgData,
  // check control
  input  logic [IDX_W:0]    NumChecks,
  input  logic [ADDR_W-1:0] IgnLo,
  input  logic [ADDR_W-1:0] IgnHi,
  input  logic [TMO_W-1:0]  Timeout,
  input  logic              Start,
  // verdict and diagnostics
  output logic              Done,
  output logic              Pass,
  output logic              Fail,
  output logic              TimedOut,
  output logic [ADDR_W-1:0] FailAdr,
  output logic [DATA_W-1:0] FailData,
  output logic [IDX_W:0]    MatchCount,
  output logic [15:0]       IgnCount
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PASS,
    ST_FAIL,
    ST_TMO
  } state_t;

  localparam logic [IDX_W:0]   CNT_ONE = 1;
  localparam logic [TMO_W-1:0] TMO_ONE = 1;
  localparam logic [15:0]      IGN_MAX = 16'hFFFF;

  state_t              state, state_nx;
  logic [IDX_W:0]      match_cnt, match_cnt_nx;   // also the table pointer
  logic [15:0]         ign_cnt, ign_cnt_nx;
  logic [TMO_W-1:0]    timer, timer_nx;
  logic [ADDR_W-1:0]   fail_adr, fail_adr_nx;
  logic [DATA_W-1:0]   fail_data, fail_data_nx;
  logic                pass_q, fail_q, tmo_q;

  logic [ADDR_W-1:0]   tbl_adr  [DEPTH];
  logic [DATA_W-1:0]   tbl_data [DEPTH];

  logic [IDX_W-1:0]    ptr_idx;
  logic [ADDR_W-1:0]   exp_adr;
  logic [DATA_W-1:0]   exp_data;
  logic                store_match;
  logic                store_in_window;
  logic                last_match;
  logic                tmo_expire;

  // Expected-write table: loadable whenever no check is running.
  // NOTE: storage arrays carry no reset; contents are only meaningful once
  // software has loaded them, and leaving them unreset lets them map to RAM.
  always_ff @(posedge clk) begin
    if (CfgWe && (state != ST_ARMED)) begin
      tbl_adr[CfgIdx]  <= CfgAdr;
      tbl_data[CfgIdx] <= CfgData;
    end
  end

  assign ptr_idx  = match_cnt[IDX_W-1:0];
  assign exp_adr  = tbl_adr[ptr_idx];
  assign exp_data = tbl_data[ptr_idx];

  assign store_match     = MemWrite && (DataAdr == exp_adr) && (WriteData == exp_data);
  assign store_in_window = (DataAdr >= IgnLo) && (DataAdr <= IgnHi);
  assign last_match      = ((match_cnt + CNT_ONE) == NumChecks);
  assign tmo_expire      = (Timeout != '0) && (timer == (Timeout - TMO_ONE));

  // Next-state and datapath update; a store verdict outranks timeout expiry.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx     = state;
    match_cnt_nx = match_cnt;
    ign_cnt_nx   = ign_cnt;
    timer_nx     = timer;
    fail_adr_nx  = fail_adr;
    fail_data_nx = fail_data;

    unique case (state)
      ST_ARMED: begin
        timer_nx = timer + TMO_ONE;
        if (store_match) begin
          match_cnt_nx = match_cnt + CNT_ONE;
          if (last_match) begin
            state_nx = ST_PASS;
          end
        end else if (MemWrite && store_in_window) begin
          if (ign_cnt != IGN_MAX) begin
            ign_cnt_nx = ign_cnt + 16'd1;
          end
        end else if (MemWrite) begin
          state_nx     = ST_FAIL;
          fail_adr_nx  = DataAdr;
          fail_data_nx = WriteData;
        end
        if ((state_nx == ST_ARMED) && tmo_expire) begin
          state_nx = ST_TMO;
        end
      end

      ST_IDLE, ST_PASS, ST_FAIL, ST_TMO: begin
        if (Start) begin
          state_nx     = (NumChecks == '0) ? ST_PASS : ST_ARMED;
          match_cnt_nx = '0;
          ign_cnt_nx   = '0;
          timer_nx     = '0;
          fail_adr_nx  = '0;
          fail_data_nx = '0;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered verdict flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      match_cnt <= '0;
      ign_cnt   <= '0;
      timer     <= '0;
      fail_adr  <= '0;
      fail_data <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      match_cnt <= match_cnt_nx;
      ign_cnt   <= ign_cnt_nx;
      timer     <= timer_nx;
      fail_adr  <= fail_adr_nx;
      fail_data <= fail_data_nx;
      pass_q    <= (state_nx == ST_PASS);
      fail_q    <= (state_nx == ST_FAIL);
      tmo_q     <= (state_nx == ST_TMO);
    end
  end

  assign Pass       = pass_q;
  assign Fail       = fail_q;
  assign TimedOut   = tmo_q;
  assign Done       = pass_q | fail_q | tmo_q;
  assign FailAdr    = fail_adr;
  assign FailData   = fail_data;
  assign MatchCount = match_cnt;
  assign IgnCount   = ign_cnt;

endmodule

// File: tb/tb_mem_write_monitor.sv
// tb_mem_write_monitor
// Directed vectors, hand-written multi-cycle sequences and randomized
// checks against a verdict-level reference model.

module tb_mem_write_monitor;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        CfgWe;
  logic [2:0]  CfgIdx;
  logic [31:0] CfgAdr;
  logic [31:0] CfgData;
  logic [3:0]  NumChecks;
  logic [31:0] IgnLo;
  logic [31:0] IgnHi;
  logic [15:0] Timeout;
  logic        Start;
  logic        Done;
  logic        Pass;
  logic        Fail;
  logic        TimedOut;
  logic [31:0] FailAdr;
  logic [31:0] FailData;
  logic [3:0]  MatchCount;
  logic [15:0] IgnCount;

  int n_tests = 0;
  int n_fail  = 0;

  mem_write_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .CfgWe      (CfgWe),
    .CfgIdx     (CfgIdx),
    .CfgAdr     (CfgAdr),
    .CfgData    (CfgData),
    .NumChecks  (NumChecks),
    .IgnLo      (IgnLo),
    .IgnHi      (IgnHi),
    .Timeout    (Timeout),
    .Start      (Start),
    .Done       (Done),
    .Pass       (Pass),
    .Fail       (Fail),
    .TimedOut   (TimedOut),
    .FailAdr    (FailAdr),
    .FailData   (FailData),
    .MatchCount (MatchCount),
    .IgnCount   (IgnCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Verdict: 0 = none, 1 = pass, 2 = fail, 3 = timed out.
  logic [31:0] m_tab_adr  [8];
  logic [31:0] m_tab_data [8];
  bit          m_armed;
  int          m_verdict;
  int          m_matched;
  int          m_ign;
  int          m_cycles;
  logic [31:0] m_fadr;
  logic [31:0] m_fdata;

  task automatic model_reset();
    m_armed   = 0;
    m_verdict = 0;
    m_matched = 0;
    m_ign     = 0;
    m_cycles  = 0;
    m_fadr    = '0;
    m_fdata   = '0;
  endtask

  task automatic model_edge();
    if (!m_armed) begin
      if (CfgWe) begin
        m_tab_adr[CfgIdx]  = CfgAdr;
        m_tab_data[CfgIdx] = CfgData;
      end
      if (Start) begin
        m_matched = 0;
        m_ign     = 0;
        m_cycles  = 0;
        m_fadr    = '0;
        m_fdata   = '0;
        if (NumChecks == 0) begin
          m_verdict = 1;
        end else begin
          m_verdict = 0;
          m_armed   = 1;
        end
      end
    end else begin
      if (MemWrite) begin
        if (DataAdr == m_tab_adr[m_matched] && WriteData == m_tab_data[m_matched]) begin
          m_matched++;
          if (m_matched == int'(NumChecks)) begin
            m_verdict = 1;
            m_armed   = 0;
          end
        end else if (DataAdr >= IgnLo && DataAdr <= IgnHi) begin
          if (m_ign < 65535) m_ign++;
        end else begin
          m_verdict = 2;
          m_armed   = 0;
          m_fadr    = DataAdr;
          m_fdata   = WriteData;
        end
      end
      m_cycles++;
      if (m_armed && Timeout != 0 && m_cycles == int'(Timeout)) begin
        m_verdict = 3;
        m_armed   = 0;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    MemWrite  = 0; DataAdr = '0; WriteData = '0;
    CfgWe     = 0; CfgIdx  = '0; CfgAdr    = '0; CfgData = '0;
    NumChecks = '0; IgnLo  = '0; IgnHi     = '0; Timeout = '0;
    Start     = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] a, input logic [31:0] d);
    CfgWe = 1; CfgIdx = 3'(idx); CfgAdr = a; CfgData = d;
    tick();
    CfgWe = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1; DataAdr = a; WriteData = d;
    tick();
    MemWrite = 0;
  endtask

  task automatic pulse_start();
    Start = 1;
    tick();
    Start = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".done"},  Done,       m_verdict != 0);
    check({tag, ".pass"},  Pass,       m_verdict == 1);
    check({tag, ".fail"},  Fail,       m_verdict == 2);
    check({tag, ".tmo"},   TimedOut,   m_verdict == 3);
    check({tag, ".fadr"},  FailAdr,    m_fadr);
    check({tag, ".fdata"}, FailData,   m_fdata);
    check({tag, ".match"}, MatchCount, m_matched);
    check({tag, ".ign"},   IgnCount,   m_ign);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".done"},  Done,       0);
    check({tag, ".pass"},  Pass,       0);
    check({tag, ".fail"},  Fail,       0);
    check({tag, ".tmo"},   TimedOut,   0);
    check({tag, ".fadr"},  FailAdr,    0);
    check({tag, ".fdata"}, FailData,   0);
    check({tag, ".match"}, MatchCount, 0);
    check({tag, ".ign"},   IgnCount,   0);
  endtask

  // ---------------- single-store vectors ----------------
  // Table entry 0 = {100, 7}, NumChecks = 1, no timeout; one store applied.
  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        exp_pass;
    logic        exp_fail;
    logic [31:0] exp_fadr;
    logic [31:0] exp_fdata;
    int          exp_match;
    int          exp_ign;
  } vec_t;

  vec_t vecs [10];

  initial begin
    clear_inputs();
    reset = 1;
    #12;
    check_zero("async_reset");
    do_reset();
    check_zero("reset");

    vecs[0] = '{32'd100,        32'd7, 32'd96, 32'd96,        1'b1, 1'b0, 32'd0,   32'd0, 1, 0};
    vecs[1] = '{32'd96,         32'd3, 32'd96, 32'd96,        1'b0, 1'b0, 32'd0,   32'd0, 0, 1};
    vecs[2] = '{32'd100,        32'd8, 32'd96, 32'd96,        1'b0, 1'b1, 32'd100, 32'd8, 0, 0};
    vecs[3] = '{32'd100,        32'd8, 32'd90, 32'd110,       1'b0, 1'b0, 32'd0,   32'd0, 0, 1};
    vecs[4] = '{32'd100,        32'd7, 32'd90, 32'd110,       1'b1, 1'b0, 32'd0,   32'd0, 1, 0};
    vecs[5] = '{32'd50,         32'd7, 32'd1,  32'd0,         1'b0, 1'b1, 32'd50,  32'd7, 0, 0};
    vecs[6] = '{32'hFFFF_FFFF,  32'd7, 32'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0,   32'd0, 0, 1};
    vecs[7] = '{32'd95,         32'd1, 32'd96, 32'd96,        1'b0, 1'b1, 32'd95,  32'd1, 0, 0};
    vecs[8] = '{32'd97,         32'd1, 32'd96, 32'd96,        1'b0, 1'b1, 32'd97,  32'd1, 0, 0};
    vecs[9] = '{32'd96,         32'd1, 32'd96, 32'd200,       1'b0, 1'b0, 32'd0,   32'd0, 0, 1};

    for (int i = 0; i < 10; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      do_reset();
      cfg_write(0, 32'd100, 32'd7);
      NumChecks = 4'd1; IgnLo = vecs[i].lo; IgnHi = vecs[i].hi; Timeout = '0;
      pulse_start();
      store(vecs[i].adr, vecs[i].data);
      check({t, ".pass"},  Pass,       vecs[i].exp_pass);
      check({t, ".fail"},  Fail,       vecs[i].exp_fail);
      check({t, ".done"},  Done,       vecs[i].exp_pass | vecs[i].exp_fail);
      check({t, ".fadr"},  FailAdr,    vecs[i].exp_fadr);
      check({t, ".fdata"}, FailData,   vecs[i].exp_fdata);
      check({t, ".match"}, MatchCount, vecs[i].exp_match);
      check({t, ".ign"},   IgnCount,   vecs[i].exp_ign);
    end

    // ---- ignored store then match: verdict one cycle after the match ----
    do_reset();
    cfg_write(0, 32'd100, 32'd7);
    NumChecks = 4'd1; IgnLo = 32'd96; IgnHi = 32'd96;
    pulse_start();
    store(32'd96, 32'd3);
    check("seq25.done_mid", Done, 0);
    MemWrite = 1; DataAdr = 32'd100; WriteData = 32'd7;
    #2;
    check("seq25.before_edge", Pass, 0);
    tick();
    MemWrite = 0;
    check("seq25.pass",  Pass,       1);
    check("seq25.ign",   IgnCount,   1);
    check("seq25.match", MatchCount, 1);

    // ---- timeout after exactly Timeout armed cycles ----
    do_reset();
    NumChecks = 4'd1; Timeout = 16'd20; IgnLo = 32'd1; IgnHi = 32'd0;
    pulse_start();
    for (int c = 1; c < 20; c++) tick();
    check("seq27.tmo_at19", TimedOut, 0);
    tick();
    check("seq27.tmo_at20", TimedOut, 1);
    check("seq27.done",     Done,     1);
    check("seq27.pass",     Pass,     0);

    // ---- Timeout = 0 never expires ----
    Timeout = '0;
    pulse_start();
    check("seq27.restart_clears", TimedOut, 0);
    for (int c = 0; c < 500; c++) tick();
    check("seq27.no_tmo_done", Done, 0);

    // ---- out-of-order store fails; later stores ignored ----
    do_reset();
    cfg_write(0, 32'd4, 32'd1);
    cfg_write(1, 32'd8, 32'd2);
    NumChecks = 4'd2; IgnLo = 32'd1; IgnHi = 32'd0;
    pulse_start();
    store(32'd8, 32'd2);
    store(32'd4, 32'd1);
    check("seq28.fail",  Fail,       1);
    check("seq28.fadr",  FailAdr,    32'd8);
    check("seq28.fdata", FailData,   32'd2);
    check("seq28.match", MatchCount, 0);

    // ---- last match coincides with timeout; CfgWe in ARMED ignored ----
    do_reset();
    cfg_write(0, 32'd4, 32'd1);
    NumChecks = 4'd1; IgnLo = 32'd1; IgnHi = 32'd0; Timeout = 16'd3;
    pulse_start();
    cfg_write(0, 32'd99, 32'd99);
    tick();
    check("seq29.armed", Done, 0);
    store(32'd4, 32'd1);
    check("seq29.pass", Pass,     1);
    check("seq29.tmo",  TimedOut, 0);
    pulse_start();
    tick();
    tick();
    check("seq29.tmo_early", TimedOut, 0);
    tick();
    check("seq29.tmo_late", TimedOut, 1);

    // ---- reset between edges mid-check, then zero-length check ----
    do_reset();
    cfg_write(0, 32'd4, 32'd1);
    cfg_write(1, 32'd8, 32'd2);
    NumChecks = 4'd2; IgnLo = 32'd20; IgnHi = 32'd30; Timeout = '0;
    pulse_start();
    store(32'd4, 32'd1);
    store(32'd25, 32'd5);
    check("seq30.match_pre", MatchCount, 1);
    check("seq30.ign_pre",   IgnCount,   1);
    #3;
    reset = 1;
    #1;
    check_zero("seq30.async");
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    store(32'd8, 32'd2);
    tick();
    check("seq30.no_done", Done, 0);
    NumChecks = '0;
    pulse_start();
    check("seq30.pass0", Pass,       1);
    check("seq30.match0", MatchCount, 0);

    // ---------------- randomized runs vs model ----------------
    do_reset();
    for (int run = 0; run < 40; run++) begin
      string t;
      t = $sformatf("rnd%0d", run);
      for (int i = 0; i < 8; i++) begin
        cfg_write(i, 32'($urandom_range(0, 15)), 32'($urandom_range(0, 3)));
      end
      check_all({t, ".cfg"});
      NumChecks = 4'($urandom_range(0, 8));
      IgnLo     = 32'($urandom_range(0, 15));
      IgnHi     = 32'($urandom_range(0, 15));
      Timeout   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      pulse_start();
      check_all({t, ".start"});
      for (int c = 0; c < 60 && m_armed; c++) begin
        MemWrite = 1'($urandom_range(0, 1));
        if (m_armed && m_matched < 8 && $urandom_range(0, 1) == 1) begin
          DataAdr   = m_tab_adr[m_matched];
          WriteData = m_tab_data[m_matched];
        end else begin
          DataAdr   = 32'($urandom_range(0, 15));
          WriteData = 32'($urandom_range(0, 3));
        end
        CfgWe   = ($urandom_range(0, 7) == 0);
        CfgIdx  = 3'($urandom_range(0, 7));
        CfgAdr  = 32'($urandom_range(0, 15));
        CfgData = 32'($urandom_range(0, 3));
        Start   = ($urandom_range(0, 15) == 0);
        tick();
        check_all({t, ".run"});
      end
      MemWrite = 1; CfgWe = 0; Start = 0;
      DataAdr = 32'($urandom_range(0, 15)); WriteData = 32'($urandom_range(0, 3));
      tick();
      check_all({t, ".post"});
      clear_inputs();
      if (m_armed) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
